multi_sum_n: RTL and testbench
==============================

# multi_sum_n

Parametrised sequential multi-operand adder for the neural-network datapath. It is the successor to the fixed four-input 32-bit summer and is used to reduce neuron partial products into one pre-activation value. It captures `N_IN` operands on a start strobe and accumulates them serially, one operand per cycle, at full precision. It then returns a `WIDTH`-bit result, either wrapped or saturated, with an overflow flag and a one-cycle done pulse.

## Interface
- `WIDTH`, 32, operand and result width in bits (≥2)
- `N_IN`, 4, number of operands (≥1)
- `SIGNED`, 1, 1 = two's-complement operands/result, 0 = unsigned
- `SATURATE`, 0, 1 = clamp result to `WIDTH` range, 0 = wrap (keep low `WIDTH` bits)

- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `in_flat`  in  `N_IN*WIDTH`  operands; operand i = `in_flat[i*WIDTH +: WIDTH]`
- `start`  in  1  request; sampled on the rising edge, accepted only in IDLE
- `sum`  out  `WIDTH`  result; holds its value until the next completion
- `done`  out  1  one-cycle pulse, result valid
- `busy`  out  1  high while an operation is in progress
- `overflow`  out  1  full-precision result was outside the `WIDTH` range; updated with `sum`

## Operation
- Internal accumulator width is `WIDTH + clog2(N_IN) + 1`, so no intermediate overflow is possible.
- Operands are sign-extended when `SIGNED`=1 and zero-extended when `SIGNED`=0.
- Operands are captured into an internal register on the accepting edge. `in_flat` may change freely afterwards.
- States and transitions:
  - IDLE: on `start`=1, capture operands, set acc←0 and idx←0, go to ACCUM.
  - ACCUM: acc←acc+op[idx] and idx←idx+1. When idx==`N_IN`-1, go to FINISH.
  - FINISH: write `sum` and `overflow`, assert `done`, return to IDLE.
- Result rule:
  - Range is [-2^(W-1), 2^(W-1)-1] when signed and [0, 2^W-1] when unsigned.
  - In range: `sum` = acc, `overflow`=0.
  - Out of range with `SATURATE`=1: `sum` = nearest bound, `overflow`=1.
  - Out of range with `SATURATE`=0: `sum` = acc[W-1:0], `overflow`=1.
- `start` is ignored while `busy`=1. It is neither queued nor does it restart the operation.
- `start` asserted in the same cycle `done` is high is accepted, because the block is in IDLE. This gives back-to-back operations.
- `N_IN`=1: ACCUM lasts one cycle. Same rules apply.

## Timing
- Reset (`reset`=0, asynchronous) immediately sets `sum`=0, `done`=0, `busy`=0, `overflow`=0, state IDLE, idx=0, acc=0.
- Release of reset is synchronous to `clk`. The first accept is possible on the first rising edge with `reset`=1.
- Reset mid-operation aborts the operation: no `done`, outputs return to their reset values.
- Accept edge T: `busy` rises after T.
- ACCUM occupies edges T+1 … T+`N_IN`. FINISH edge is T+`N_IN`+1.
- After edge T+`N_IN`+1:
  - `done`=1 for exactly one cycle.
  - `busy`=0.
  - `sum` and `overflow` are valid and stay valid until the next FINISH or reset.
- Latency is `N_IN`+1 cycles from the accepting edge to `done`. Throughput is one result per `N_IN`+1 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Defaults, reset released, operands 2,3,4,5, `start` pulsed for one cycle:
  - `sum`=14, `overflow`=0.
  - `done` high for exactly one cycle, 5 edges after accept.
  - `busy` high for those 5 cycles.
  - After that, repeat with 1,1,1,1 → `sum`=4.
- `SIGNED`=1, operands -5,3,-7,2 → `sum`=32'hFFFFFFF9 (-7), `overflow`=0. Change `in_flat` the cycle after accept → result unchanged.
- `WIDTH`=8, `SIGNED`=1, operands 100,100,100,100:
  - `SATURATE`=1 → `sum`=8'h7F, `overflow`=1.
  - `SATURATE`=0 → `sum`=8'h90, `overflow`=1.
  - Operands -100 ×4 with `SATURATE`=1 → `sum`=8'h80, `overflow`=1.
- `WIDTH`=8, `SIGNED`=0, `SATURATE`=1, operands 255 ×4 → `sum`=8'hFF, `overflow`=1. `N_IN`=1, operand 7 → `sum`=7, `done` 2 edges after accept.
- `start` re-pulsed 2 cycles after accept → ignored: a single `done`, same latency. `start` held high through `done` → second operation accepted on the `done` cycle, second `done` `N_IN`+1 edges later.
- `reset` driven low 2 cycles after accept → `busy`, `done`, `sum` and `overflow` go to 0 immediately. No `done` appears afterwards. A fresh start after release completes normally.

Source files
------------

// File: rtl/multi_sum_n.sv
// Sequential multi-operand adder: captures N_IN operands on start, sums them one per
// cycle at full precision, then returns a wrapped or saturated WIDTH-bit result.
//
// state  | meaning
// IDLE   | waiting for start; operands are captured on the accepting edge
// ACCUM  | adds one captured operand per cycle into the wide accumulator
// FINISH | range-checks the accumulator, updates sum/overflow, pulses done
module multi_sum_n #(
    parameter int WIDTH    = 32,
    parameter int N_IN     = 4,
    parameter int SIGNED   = 1,
    parameter int SATURATE = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_IN*WIDTH-1:0]  in_flat,
    input  logic                   start,
    output logic [WIDTH-1:0]       sum,
    output logic                   done,
    output logic                   busy,
    output logic                   overflow
);

    localparam int AW = WIDTH + $clog2(N_IN) + 1;
    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_IN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [AW-1:0]    acc;
    logic [WIDTH-1:0] ops [N_IN];

    logic             sign_ext;
    logic [AW-1:0]    op_ext;
    logic [WIDTH-1:0] res;
    logic             res_ovf;

    always_comb begin
        sign_ext = (SIGNED != 0) && ops[idx][WIDTH-1];
        op_ext   = {{(AW-WIDTH){sign_ext}}, ops[idx]};
    end

    // Signed results fit when every bit from WIDTH-1 upward matches the sign.
    always_comb begin
        res     = acc[WIDTH-1:0];
        res_ovf = 1'b0;
        if (SIGNED != 0) begin
            if ((acc[AW-1:WIDTH-1] != '0) && (acc[AW-1:WIDTH-1] != '1)) begin
                res_ovf = 1'b1;
                if (SATURATE != 0) begin
                    res = acc[AW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end
        end else if (acc[AW-1:WIDTH] != '0) begin
            res_ovf = 1'b1;
            if (SATURATE != 0) begin
                res = '1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            acc      <= '0;
            sum      <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                ops[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N_IN; i++) begin
                            ops[i] <= in_flat[i*WIDTH +: WIDTH];
                        end
                        acc   <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc + op_ext;
                    idx <= idx + IW'(1);
                    if (idx == LAST_IDX) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    sum      <= res;
                    overflow <= res_ovf;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_sum_n.sv
// Bench for multi_sum_n: five parameterisations share clock and reset; a vector table
// plus hand-written sequences for back-to-back, ignored start and mid-operation reset.
module tb_multi_sum_n;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [4:0]   start = '0;
    logic [127:0] in0 = '0;
    logic [31:0]  in1 = '0, in2 = '0, in3 = '0;
    logic [7:0]   in4 = '0;
    logic [31:0]  sum0;
    logic [7:0]   sum1, sum2, sum3, sum4;
    logic         d0, d1, d2, d3, d4;
    logic         b0, b1, b2, b3, b4;
    logic         o0, o1, o2, o3, o4;
    logic [4:0]   done_v, busy_v, ovf_v;

    assign done_v = {d4, d3, d2, d1, d0};
    assign busy_v = {b4, b3, b2, b1, b0};
    assign ovf_v  = {o4, o3, o2, o1, o0};

    always #5 clk = ~clk;

    multi_sum_n u0 (.clk(clk), .reset(reset), .in_flat(in0), .start(start[0]),
                    .sum(sum0), .done(d0), .busy(b0), .overflow(o0));
    multi_sum_n #(.WIDTH(8), .N_IN(4), .SIGNED(1), .SATURATE(1)) u1 (
        .clk(clk), .reset(reset), .in_flat(in1), .start(start[1]),
        .sum(sum1), .done(d1), .busy(b1), .overflow(o1));
    multi_sum_n #(.WIDTH(8), .N_IN(4), .SIGNED(1), .SATURATE(0)) u2 (
        .clk(clk), .reset(reset), .in_flat(in2), .start(start[2]),
        .sum(sum2), .done(d2), .busy(b2), .overflow(o2));
    multi_sum_n #(.WIDTH(8), .N_IN(4), .SIGNED(0), .SATURATE(1)) u3 (
        .clk(clk), .reset(reset), .in_flat(in3), .start(start[3]),
        .sum(sum3), .done(d3), .busy(b3), .overflow(o3));
    multi_sum_n #(.WIDTH(8), .N_IN(1), .SIGNED(1), .SATURATE(0)) u4 (
        .clk(clk), .reset(reset), .in_flat(in4), .start(start[4]),
        .sum(sum4), .done(d4), .busy(b4), .overflow(o4));

    typedef struct {
        int               sel;
        logic [3:0][31:0] op;
        logic [31:0]      es;
        logic             eo;
    } vec_t;

    typedef struct {
        int          sel;
        logic [31:0] es;
        logic        eo;
    } sb_t;

    sb_t  sb[$];
    vec_t vt[$];
    int   checks = 0;
    int   failures = 0;
    int   done_cnt[5] = '{default: 0};

    function automatic logic [31:0] act_sum(int s);
        case (s)
            0:       return sum0;
            1:       return {24'd0, sum1};
            2:       return {24'd0, sum2};
            3:       return {24'd0, sum3};
            default: return {24'd0, sum4};
        endcase
    endfunction

    function automatic vec_t mk(int s, logic [31:0] a, logic [31:0] b, logic [31:0] c,
                                logic [31:0] d, logic [31:0] es, logic eo);
        vec_t r;
        r.sel = s;
        r.op  = {d, c, b, a};
        r.es  = es;
        r.eo  = eo;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_ops(input int sel, input logic [3:0][31:0] o);
        case (sel)
            0:       in0 = {o[3], o[2], o[1], o[0]};
            1:       in1 = {o[3][7:0], o[2][7:0], o[1][7:0], o[0][7:0]};
            2:       in2 = {o[3][7:0], o[2][7:0], o[1][7:0], o[0][7:0]};
            3:       in3 = {o[3][7:0], o[2][7:0], o[1][7:0], o[0][7:0]};
            default: in4 = o[0][7:0];
        endcase
    endtask

    task automatic chk_reset_all(input string nm);
        for (int k = 0; k < 5; k++) begin
            chk({nm, "_sum"}, act_sum(k), 32'd0);
            chk({nm, "_busy"}, {31'd0, busy_v[k]}, 32'd0);
            chk({nm, "_done"}, {31'd0, done_v[k]}, 32'd0);
            chk({nm, "_ovf"}, {31'd0, ovf_v[k]}, 32'd0);
        end
    endtask

    // Operands are scrambled right after the accepting edge to prove they were captured.
    task automatic run_op(input vec_t v);
        int e;
        bit busy_ok;
        int nexp;
        nexp = (v.sel == 4) ? 2 : 5;
        @(negedge clk);
        drive_ops(v.sel, v.op);
        start[v.sel] = 1'b1;
        sb.push_back('{v.sel, v.es, v.eo});
        @(posedge clk);
        @(negedge clk);
        start[v.sel] = 1'b0;
        drive_ops(v.sel, {$urandom, $urandom, $urandom, $urandom});
        e = 0;
        busy_ok = 1'b1;
        while (done_v[v.sel] !== 1'b1 && e < 30) begin
            if (busy_v[v.sel] !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            e++;
        end
        chk("latency", e, nexp);
        chk("busy_during", {31'd0, busy_ok}, 32'd1);
        chk("busy_at_done", {31'd0, busy_v[v.sel]}, 32'd0);
        @(negedge clk);
        chk("done_pulse", {31'd0, done_v[v.sel]}, 32'd0);
        chk("sum_hold", act_sum(v.sel), v.es);
    endtask

    always @(negedge clk) begin
        sb_t ex;
        for (int k = 0; k < 5; k++) begin
            if (done_v[k] === 1'b1) begin
                done_cnt[k]++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_done inst=%0d actual=done required=none at %0t",
                             k, $time);
                end else begin
                    ex = sb.pop_front();
                    chk("sb_inst", k, ex.sel);
                    chk("sb_sum", act_sum(k), ex.es);
                    chk("sb_ovf", {31'd0, ovf_v[k]}, {31'd0, ex.eo});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int e;
        int cnt;

        vt.push_back(mk(0, 32'd2, 32'd3, 32'd4, 32'd5, 32'd14, 1'b0));
        vt.push_back(mk(0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd4, 1'b0));
        vt.push_back(mk(0, 32'hFFFFFFFB, 32'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF9, 1'b0));
        vt.push_back(mk(0, 32'h7FFFFFFF, 32'd1, 32'd0, 32'd0, 32'h80000000, 1'b1));
        vt.push_back(mk(0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 32'h7FFFFFFF, 1'b1));
        vt.push_back(mk(0, 32'h80000000, 32'h7FFFFFFF, 32'd1, 32'd0, 32'd0, 1'b0));
        vt.push_back(mk(1, 32'h64, 32'h64, 32'h64, 32'h64, 32'h7F, 1'b1));
        vt.push_back(mk(1, 32'h9C, 32'h9C, 32'h9C, 32'h9C, 32'h80, 1'b1));
        vt.push_back(mk(1, 32'h7F, 32'h00, 32'h00, 32'h00, 32'h7F, 1'b0));
        vt.push_back(mk(1, 32'h7F, 32'h01, 32'h00, 32'h00, 32'h7F, 1'b1));
        vt.push_back(mk(1, 32'h80, 32'hFF, 32'h00, 32'h00, 32'h80, 1'b1));
        vt.push_back(mk(1, 32'h80, 32'h00, 32'h00, 32'h00, 32'h80, 1'b0));
        vt.push_back(mk(2, 32'h64, 32'h64, 32'h64, 32'h64, 32'h90, 1'b1));
        vt.push_back(mk(2, 32'h9C, 32'h9C, 32'h9C, 32'h9C, 32'h70, 1'b1));
        vt.push_back(mk(2, 32'h40, 32'h40, 32'h00, 32'h00, 32'h80, 1'b1));
        vt.push_back(mk(3, 32'hFF, 32'hFF, 32'hFF, 32'hFF, 32'hFF, 1'b1));
        vt.push_back(mk(3, 32'hFF, 32'h00, 32'h00, 32'h00, 32'hFF, 1'b0));
        vt.push_back(mk(3, 32'h10, 32'h20, 32'h30, 32'h40, 32'hA0, 1'b0));
        vt.push_back(mk(3, 32'hFF, 32'h01, 32'h00, 32'h00, 32'hFF, 1'b1));
        vt.push_back(mk(4, 32'h07, 32'h00, 32'h00, 32'h00, 32'h07, 1'b0));
        vt.push_back(mk(4, 32'h80, 32'h00, 32'h00, 32'h00, 32'h80, 1'b0));
        vt.push_back(mk(4, 32'hF9, 32'h00, 32'h00, 32'h00, 32'hF9, 1'b0));

        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_all("reset_init");
        @(negedge clk);
        reset = 1'b1;

        foreach (vt[i]) run_op(vt[i]);

        // start held high through done: second operation accepted on the done cycle
        @(negedge clk);
        drive_ops(0, {32'd0, 32'd0, 32'd20, 32'd10});
        start[0] = 1'b1;
        sb.push_back('{0, 32'd30, 1'b0});
        @(posedge clk);
        @(negedge clk);
        e = 0;
        while (done_v[0] !== 1'b1 && e < 30) begin
            @(negedge clk);
            e++;
        end
        chk("b2b_first_latency", e, 5);
        drive_ops(0, {32'd7, 32'd7, 32'd7, 32'd7});
        sb.push_back('{0, 32'd28, 1'b0});
        @(posedge clk);
        @(negedge clk);
        start[0] = 1'b0;
        chk("b2b_busy", {31'd0, busy_v[0]}, 32'd1);
        e = 0;
        while (done_v[0] !== 1'b1 && e < 30) begin
            @(negedge clk);
            e++;
        end
        chk("b2b_second_latency", e, 5);

        // start re-pulsed while busy is ignored
        repeat (2) @(negedge clk);
        cnt = done_cnt[0];
        drive_ops(0, {32'd9, 32'd9, 32'd9, 32'd9});
        start[0] = 1'b1;
        sb.push_back('{0, 32'd36, 1'b0});
        @(posedge clk);
        @(negedge clk);
        start[0] = 1'b0;
        e = 0;
        @(negedge clk);
        e++;
        start[0] = 1'b1;
        @(negedge clk);
        e++;
        start[0] = 1'b0;
        while (done_v[0] !== 1'b1 && e < 30) begin
            @(negedge clk);
            e++;
        end
        chk("repulse_latency", e, 5);
        repeat (12) @(negedge clk);
        chk("repulse_single_done", done_cnt[0] - cnt, 1);

        // reset two cycles after accept aborts the operation asynchronously
        @(negedge clk);
        drive_ops(0, {32'd4, 32'd3, 32'd2, 32'd1});
        start[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[0] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_all("reset_mid");
        cnt = done_cnt[0];
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("reset_no_done", done_cnt[0] - cnt, 0);
        run_op(mk(0, 32'd5, 32'd6, 32'd7, 32'd8, 32'd26, 1'b0));

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
